// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte-lane masking and alignment checks.
package lsu_pkg;

  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    MERGE    = 3'd3,
    WR_ISSUE = 3'd4,
    RESP     = 3'd5
  } state_e;

  // Lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [NUM_LANES-1:0] lane_mask(size_e sz, logic [2:0] off);
    logic [NUM_LANES-1:0] m;
    case (sz)
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << off;
      SZ_W:    m = 8'h0f << off;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(size_e sz, logic [2:0] off);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel and memory-side bus of the load/store unit.
interface lsu_core_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              En;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] read_data;

  modport master (
    output En, address, write_data, memRead, memWrite,
    input  read_data
  );
  modport slave (
    input  En, address, write_data, memRead, memWrite,
    output read_data
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extract/extend a load field from a doubleword and
// merge store bytes into a doubleword. Reused by future cache fill logic.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [2:0]  off,
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  output logic [63:0] ld_data,
  output logic [63:0] st_data
);

  logic [5:0]                        sh;
  logic [63:0]                       fld;
  logic [NUM_LANES-1:0][LANE_W-1:0]  wsh;
  logic [NUM_LANES-1:0][LANE_W-1:0]  line_l;
  logic [NUM_LANES-1:0][LANE_W-1:0]  st_l;
  logic [NUM_LANES-1:0]              mask;

  assign sh     = {off, 3'b000};
  assign fld    = line >> sh;
  assign wsh    = wdata << sh;
  assign line_l = line;
  assign mask   = lane_mask(size, off);

  always_comb begin
    ld_data = fld;
    case (size)
      SZ_B:    ld_data = {{56{sign_ext & fld[7]}},  fld[7:0]};
      SZ_H:    ld_data = {{48{sign_ext & fld[15]}}, fld[15:0]};
      SZ_W:    ld_data = {{32{sign_ext & fld[31]}}, fld[31:0]};
      default: ld_data = fld;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_l[i] = mask[i] ? wsh[i] : line_l[i];
  end

  assign st_data = st_l;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store master for a 64-bit doubleword memory, with
// sub-doubleword loads (extract/extend) and stores (read-modify-write).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  size_e               size_q, size_d;
  logic                sext_q, sext_d;
  logic [2:0]          off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   line_q, line_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  size_e               req_sz;
  logic                req_mis;
  logic [DATA_W-1:0]   line_in;
  logic [DATA_W-1:0]   ld_data;
  logic [DATA_W-1:0]   st_data;

  assign req_sz  = size_e'(core.req_size);
  assign req_mis = misaligned(req_sz, core.req_addr[2:0]);

  // Loads extend straight from the bus on the sampling edge; merges use the captured line.
  assign line_in = (state_q == RD_WAIT) ? mem.read_data : line_q;

  lsu_align u_align (
    .size     (size_q),
    .sign_ext (sext_q),
    .off      (off_q),
    .line     (line_in),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    size_d    = size_q;
    sext_d    = sext_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    line_d    = line_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          write_d = core.req_write;
          size_d  = req_sz;
          sext_d  = core.req_signed;
          off_d   = core.req_addr[2:0];
          wdata_d = core.req_wdata;
          addr_d  = {3'b000, core.req_addr[ADDR_W-1:3]};
          rdata_d = '0;
          err_d   = req_mis;
          if (req_mis) begin
            state_d = RESP;
          end else if (core.req_write && req_sz == SZ_D) begin
            wr_data_d = core.req_wdata;
            state_d   = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        cnt_d   = 3'(RD_LAT - 1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          if (write_q) begin
            line_d  = mem.read_data;
            state_d = MERGE;
          end else begin
            rdata_d = ld_data;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      MERGE: begin
        wr_data_d = st_data;
        state_d   = WR_ISSUE;
      end
      WR_ISSUE: state_d = RESP;
      RESP: begin
        if (core.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      size_q    <= SZ_B;
      sext_q    <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode straight from state, so a reset edge drops them immediately.
  assign core.req_ready  = (state_q == IDLE);
  assign core.resp_valid = (state_q == RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_error = err_q;

  assign mem.En         = (state_q == RD_ISSUE) || (state_q == RD_WAIT) || (state_q == WR_ISSUE);
  assign mem.memRead    = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
  assign mem.memWrite   = (state_q == WR_ISSUE);
  assign mem.address    = addr_q;
  assign mem.write_data = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level
// memory reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  lsu_core_if core ();
  lsu_mem_if  mem_if ();

  load_store_unit #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .core  (core),
    .mem   (mem_if)
  );

  logic [63:0] dmem    [16];
  logic [63:0] ref_mem [16];
  logic        bd_we   = 1'b0;
  logic [3:0]  bd_idx  = '0;
  logic [63:0] bd_data = '0;
  int          wr_cnt = 0, strobe_cnt = 0, bad_strobe = 0;
  logic [63:0] last_wd = '0, last_wa = '0;

  always @(posedge Clk) begin
    if (bd_we) dmem[bd_idx] <= bd_data;
    else if (mem_if.En && mem_if.memWrite) begin
      dmem[mem_if.address[3:0]] <= mem_if.write_data;
      wr_cnt  <= wr_cnt + 1;
      last_wd <= mem_if.write_data;
      last_wa <= mem_if.address;
    end
    if (mem_if.En && mem_if.memRead) mem_if.read_data <= dmem[mem_if.address[3:0]];
  end

  always @(negedge Clk) begin
    if (mem_if.En || mem_if.memRead || mem_if.memWrite) strobe_cnt <= strobe_cnt + 1;
    if (Rst_n && ((mem_if.memRead && mem_if.memWrite) ||
                  (!mem_if.En && (mem_if.memRead || mem_if.memWrite))))
      bad_strobe <= bad_strobe + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(logic [63:0] dw, int off, int nb, bit sg);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
    if (sg && nb < 8 && v[8*nb-1])
      for (int j = nb; j < 8; j++) v[8*j +: 8] = 8'hff;
    return v;
  endfunction

  function automatic logic [63:0] ref_store(logic [63:0] dw, int off, int nb, logic [63:0] wd);
    logic [63:0] v = dw;
    for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  task automatic poke(input int idx, input logic [63:0] data);
    @(negedge Clk);
    bd_we = 1'b1; bd_idx = 4'(idx); bd_data = data;
    ref_mem[idx] = data;
    @(posedge Clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic step_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [63:0] a, input logic [63:0] wd);
    @(negedge Clk);
    core.req_valid = 1'b1; core.req_write = w; core.req_size = sz;
    core.req_signed = sg; core.req_addr = a; core.req_wdata = wd;
    @(posedge Clk); #1;
    core.req_valid = 1'b0;
  endtask

  // lat counts cycles after the accept cycle until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge Clk);
    while (!core.resp_valid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic take_resp();
    core.resp_ready = 1'b1;
    @(posedge Clk); #1;
    core.resp_ready = 1'b0;
  endtask

  task automatic run_checked(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                             input logic [63:0] a, input logic [63:0] wd,
                             output logic [63:0] rd, output logic er, output int lat);
    int nb, off, idx, exp_lat;
    logic [63:0] exp_rd;
    logic        exp_er;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    idx = int'(a[6:3]);
    exp_er = (off % nb) != 0;
    exp_rd = '0;
    exp_lat = exp_er ? 1 : (!w ? 3 : (nb == 8 ? 2 : 0));
    if (!exp_er) begin
      if (w) ref_mem[idx] = ref_store(ref_mem[idx], off, nb, wd);
      else   exp_rd = ref_load(ref_mem[idx], off, nb, sg);
    end
    step_req(w, sz, sg, a, wd);
    wait_resp(lat);
    check({tag, "_valid"}, 64'(core.resp_valid), 64'd1);
    rd = core.resp_rdata;
    er = core.resp_error;
    take_resp();
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 64'(er), 64'(exp_er));
    if (exp_lat != 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  logic [63:0] rd, rd0;
  logic        er;
  int          lat, w0, s0;

  initial begin
    core.req_valid = 1'b0; core.req_write = 1'b0; core.req_size = 2'd0;
    core.req_signed = 1'b0; core.req_addr = '0; core.req_wdata = '0;
    core.resp_ready = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_req_ready",  64'(core.req_ready),     64'd1);
    check("rst_resp_valid", 64'(core.resp_valid),    64'd0);
    check("rst_resp_rdata", core.resp_rdata,         64'd0);
    check("rst_resp_error", 64'(core.resp_error),    64'd0);
    check("rst_en",         64'(mem_if.En),          64'd0);
    check("rst_memread",    64'(mem_if.memRead),     64'd0);
    check("rst_memwrite",   64'(mem_if.memWrite),    64'd0);
    check("rst_address",    mem_if.address,          64'd0);
    check("rst_write_data", mem_if.write_data,       64'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) poke(i, {$urandom, $urandom});

    // Double store then double load at addr 8
    w0 = wr_cnt;
    run_checked("st_d", 1'b1, 2'd3, 1'b0, 64'h8, 64'h0102030405060708, rd, er, lat);
    check("st_d_wcnt", 64'(wr_cnt - w0), 64'd1);
    check("st_d_waddr", last_wa, 64'd1);
    check("st_d_wdata", last_wd, 64'h0102030405060708);
    run_checked("ld_d", 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, rd, er, lat);
    check("ld_d_const", rd, 64'h0102030405060708);

    // Byte read-modify-write and signed/unsigned reload
    poke(1, 64'h1111111111111111);
    run_checked("st_b", 1'b1, 2'd0, 1'b0, 64'h0B, 64'hAB, rd, er, lat);
    check("st_b_wdata", last_wd, 64'h11111111AB111111);
    run_checked("ld_bs", 1'b0, 2'd0, 1'b1, 64'h0B, 64'h0, rd, er, lat);
    check("ld_bs_const", rd, 64'hFFFFFFFFFFFFFFAB);
    run_checked("ld_bu", 1'b0, 2'd0, 1'b0, 64'h0B, 64'h0, rd, er, lat);
    check("ld_bu_const", rd, 64'hAB);

    // Half load sign handling
    poke(2, 64'h0000800000000000);
    run_checked("ld_hs", 1'b0, 2'd1, 1'b1, 64'h14, 64'h0, rd, er, lat);
    check("ld_hs_const", rd, 64'hFFFFFFFFFFFF8000);
    run_checked("ld_hu", 1'b0, 2'd1, 1'b0, 64'h14, 64'h0, rd, er, lat);
    check("ld_hu_const", rd, 64'h8000);

    // Misaligned word load issues no strobes
    s0 = strobe_cnt;
    run_checked("mis_w", 1'b0, 2'd2, 1'b0, 64'h0A, 64'h0, rd, er, lat);
    check("mis_w_err", 64'(er), 64'd1);
    check("mis_w_rdata", rd, 64'd0);
    check("mis_w_strobes", 64'(strobe_cnt - s0), 64'd0);

    // Response backpressure with a competing request
    step_req(1'b0, 2'd3, 1'b0, 64'h8, 64'h0);
    wait_resp(lat);
    rd0 = core.resp_rdata;
    check("bp_first", rd0, ref_mem[1]);
    core.req_valid = 1'b1; core.req_write = 1'b0; core.req_size = 2'd0;
    core.req_signed = 1'b0; core.req_addr = 64'h0B;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(core.resp_valid), 64'd1);
      check("bp_hold",  core.resp_rdata, rd0);
      check("bp_ready", 64'(core.req_ready), 64'd0);
      @(negedge Clk);
    end
    core.resp_ready = 1'b1;
    @(posedge Clk); #1;
    core.resp_ready = 1'b0;
    @(negedge Clk);
    check("bp_idle_ready", 64'(core.req_ready), 64'd1);
    check("bp_idle_valid", 64'(core.resp_valid), 64'd0);
    @(posedge Clk); #1;
    core.req_valid = 1'b0;
    wait_resp(lat);
    check("bp_next_lat", 64'(lat), 64'd3);
    check("bp_next_rdata", core.resp_rdata, ref_load(ref_mem[1], 3, 1, 1'b0));
    take_resp();

    // Reset during MERGE aborts the store
    poke(1, 64'h1111111111111111);
    w0 = wr_cnt;
    step_req(1'b1, 2'd0, 1'b0, 64'h0B, 64'hCD);
    @(negedge Clk);
    check("rr_issue_rd", 64'(mem_if.memRead), 64'd1);
    @(negedge Clk);
    @(negedge Clk);
    check("rr_merge_en", 64'(mem_if.En), 64'd0);
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("rr_req_ready",  64'(core.req_ready),  64'd1);
    check("rr_resp_valid", 64'(core.resp_valid), 64'd0);
    check("rr_en",         64'(mem_if.En),       64'd0);
    check("rr_memwrite",   64'(mem_if.memWrite), 64'd0);
    check("rr_address",    mem_if.address,       64'd0);
    check("rr_write_data", mem_if.write_data,    64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rr_no_write", 64'(wr_cnt - w0), 64'd0);
    check("rr_mem1", dmem[1], 64'h1111111111111111);

    // Randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      run_checked("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 64'($urandom_range(0, 127)),
                  {$urandom, $urandom}, rd, er, lat);
    end

    @(negedge Clk);
    for (int i = 0; i < 16; i++) check("mem_final", dmem[i], ref_mem[i]);
    check("strobe_rules", 64'(bad_strobe), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
